// File: rtl/rotacion_izquierda_iterativa.sv
// Rotates an operand left by one bit per clock and returns it with an ARM-style carry-out.
// A start pulse is accepted only while the unit is not busy. The done pulse marks a newly written z/c.
module rotacion_izquierda_iterativa #(
  parameter int N  = 32,
  parameter int CW = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] z,
  output logic         c,
  output logic         busy,
  output logic         done,
  output logic [1:0]   dbg_state
);

  // Handshake: start is sampled at a rising edge only when busy=0. done is a
  // one-cycle pulse, and z/c are valid from that cycle until the next done.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROT  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   work_q, work_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   z_d;
  logic           c_d, busy_d, done_d;
  logic [CW-1:0]  k;
  logic [N-1:0]   rot;

  assign k         = b[CW-1:0];
  assign rot       = {work_q[N-2:0], work_q[N-1]};
  assign dbg_state = state_q;

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    z_d     = z;
    c_d     = c;
    busy_d  = busy;
    done_d  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
        if (start) begin
          work_d = a;
          cnt_d  = k;
          if (k == '0) begin
            // Rotating by zero leaves the carry untouched.
            z_d     = a;
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ROT;
            busy_d  = 1'b1;
          end
        end
      end
      ROT: begin
        work_d = rot;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          z_d     = rot;
          c_d     = work_q[N-1];
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      z       <= '0;
      c       <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      z       <= z_d;
      c       <= c_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

endmodule

// File: tb/tb_rotacion_izquierda_iterativa.sv
// Bench for rotacion_izquierda_iterativa. Drivers queue the expected {c,z}, the done cycle, the busy
// length and the operand. A monitor compares them against every done pulse.
module tb_rotacion_izquierda_iterativa;
  localparam int N = 32;
  localparam int W = N + 1;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [N-1:0] a, b, z;
  logic         c, busy, done;
  logic [1:0]   dbg_state;

  rotacion_izquierda_iterativa #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .z(z), .c(c), .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [W-1:0] exp_q[$];
  int           exp_t_q[$];
  int           exp_k_q[$];
  logic [N-1:0] exp_a_q[$];
  int           tests = 0;
  int           fails = 0;
  logic         last_c = 1'b0;

  function automatic logic [N-1:0] rol(input logic [N-1:0] x, input int k);
    if (k == 0) return x;
    return (x << k) | (x >> (N - k));
  endfunction

  function automatic logic [N-1:0] ror(input logic [N-1:0] x, input int k);
    if (k == 0) return x;
    return (x >> k) | (x << (N - k));
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called at a negedge: waits until the DUT is free, then pulses start for one cycle.
  task automatic issue(input logic [N-1:0] av, input logic [N-1:0] bv,
                       input logic [N-1:0] ez, input logic ec);
    int n;
    int kk;
    n  = 0;
    kk = int'(bv % N);
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("issue_wait_busy", {63'd0, busy}, 64'd0);
    a     = av;
    b     = bv;
    start = 1'b1;
    exp_q.push_back({ec, ez});
    exp_t_q.push_back(cyc + 1 + kk);
    exp_k_q.push_back(kk);
    exp_a_q.push_back(av);
    last_c = ec;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("drain_pending", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    fork
      begin : monitor
        logic [W-1:0] e;
        logic [N-1:0] a0;
        int t, kk, run;
        run = 0;
        forever begin
          @(negedge clk);
          if (busy) begin
            run++;
          end else if (done) begin
            if (exp_q.size() == 0) begin
              check("unexpected_done", {31'd0, c, z}, 64'd0 - 64'd1);
            end else begin
              e  = exp_q.pop_front();
              t  = exp_t_q.pop_front();
              kk = exp_k_q.pop_front();
              a0 = exp_a_q.pop_front();
              check("result_cz", {31'd0, c, z}, {31'd0, e});
              check("done_cycle", 64'(cyc), 64'(t));
              check("busy_cycles", 64'(run), 64'(kk));
              check("ror_restore", {32'd0, ror(z, kk)}, {32'd0, a0});
            end
            run = 0;
          end else begin
            run = 0;
          end
        end
      end
      begin : driver
        logic [N-1:0] av, ez;
        int n;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset_state", {29'd0, z, c, busy, done}, 64'd0);

        issue(32'h8000_0001, 32'd1, 32'h0000_0003, 1'b1);
        drain();

        issue(32'h1234_5678, 32'd4, 32'h2345_6781, 1'b1);
        drain();
        repeat (5) @(negedge clk);
        check("z_hold", {31'd0, c, z}, {31'd0, 1'b1, 32'h2345_6781});

        issue(32'hDEAD_BEEF, 32'd0, 32'hDEAD_BEEF, 1'b1);
        drain();
        issue(32'hDEAD_BEEF, 32'd32, 32'hDEAD_BEEF, 1'b1);
        drain();

        // The second start lands while the rotation is busy and must be ignored.
        issue(32'h0000_0001, 32'd33, 32'h0000_0002, 1'b0);
        a     = 32'hFFFF_FFFF;
        b     = 32'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain();
        repeat (6) @(negedge clk);

        // A new start is issued in the DONE cycle.
        issue(32'h0000_00FF, 32'd2, 32'h0000_03FC, 1'b0);
        n = 0;
        while (!done && n < 50) begin
          @(negedge clk);
          n++;
        end
        check("b2b_done_seen", {63'd0, done}, 64'd1);
        issue(32'hF000_0000, 32'd4, 32'h0000_000F, 1'b1);
        drain();

        // A reset in the third cycle of the rotation discards the operation.
        issue(32'hA5A5_A5A5, 32'd8, 32'hA5A5_A5A5, 1'b1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        exp_t_q.delete();
        exp_k_q.delete();
        exp_a_q.delete();
        last_c = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("mid_reset_state", {29'd0, z, c, busy, done}, 64'd0);
        repeat (12) @(negedge clk);

        for (int k = 0; k < 8; k++) begin
          av = $urandom;
          ez = rol(av, k);
          issue(av, k, ez, (k == 0) ? last_c : ez[0]);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
      end
    join
  end

endmodule

// File: doc/rotacion_izquierda_iterativa.md
Name: rotacion_izquierda_iterativa

Overview:
- Sequential left-rotate unit for the ALU operation set. It is the inverse of the combinational right circular shift.
- Takes an operand and a rotate amount. Rotates one bit position per clock, left and circular.
- Signals completion with a one-cycle done pulse and returns the ARM-style carry-out.
- Used for rotate-left or undo-ROR micro-ops where area matters more than latency.

Parameters:
- N, 32, operand width in bits. Must be a power of two and at least 2.
- CW, $clog2(N), width of the internal amount counter.

Ports:
- clk  input  1  single system clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- start  input  1  request pulse; sampled only while busy=0.
- a  input  N  operand to rotate; captured when start is accepted.
- b  input  N  rotate amount; only b[CW-1:0] is used (amount k = b mod N); captured with a.
- z  output  N  rotated result; held between operations.
- c  output  1  carry-out (last bit rotated from MSB into LSB).
- busy  output  1  high while a rotation is in progress.
- done  output  1  one-cycle pulse; z and c are valid and newly updated.

Behaviour:
- Reset (rst=1 at an edge, from any state, including mid-rotation):
  - state<=IDLE, z<=0, c<=0, busy<=0, done<=0, counter<=0.
  - Any rotation in flight is discarded.
- States: IDLE, ROT, DONE. All outputs are registered.
- Start acceptance:
  - start is accepted at an edge when state is IDLE or DONE (busy=0).
  - Accepted start loads work<=a and cnt<=k.
  - In ROT, start is ignored entirely: no effect, no queuing.
- Accept with k=0: z<=a, c unchanged (ARM shift-by-zero rule), state<=DONE.
- Accept with k>0: state<=ROT, busy<=1.
- Each edge in ROT:
  - work<={work[N-2:0],work[N-1]}; cnt<=cnt-1.
  - When cnt==1, also: z<=rotated value, c<=rotated value bit 0, state<=DONE, busy<=0.
- DONE:
  - done=1 for exactly one cycle.
  - Next edge goes to IDLE, or reloads if start=1 (back-to-back is allowed, so done may be followed immediately by a new operation).
- Latency: with start accepted at edge E0, done is high in the cycle after edge E0+k (k=0 gives the next cycle). busy is high for k cycles.
- z and c change only at the edge where done rises; they are stable at all other times.
- Amount wrap: b>=N uses the low CW bits, so b=N behaves as k=0 and b=N+1 as k=1.
- Result identity: z = a rotated left by k. Right-rotating z by k must restore a.
- No combinational path from any input to any output.

Test Plan:
- rst held 2 cycles, then released -> z=0, c=0, busy=0, done=0. start with a=0x80000001, b=1 -> busy 1 cycle, done next cycle, z=0x00000003, c=1.
- a=0x12345678, b=4 -> busy for exactly 4 cycles, then done pulse for 1 cycle, z=0x23456781, c=1. z stays 0x23456781 afterwards with no new start.
- a=0xDEADBEEF, b=0 after a previous op left c=1 -> done in the next cycle, z=0xDEADBEEF, c remains 1. Repeat with b=32 -> identical result.
- start a=0x00000001, b=33 -> treated as k=1, z=0x00000002, c=0. A second start pulse issued during busy is ignored, and only one done pulse is seen.
- Back-to-back: start asserted in the DONE cycle with a=0xF0000000, b=4 -> next done gives z=0x0000000F, c=1, with no idle cycle between.
- rst asserted in the 3rd cycle of a b=8 rotation -> next cycle z=0, c=0, busy=0, and no done pulse. Random sweep for k in 0..7 -> right-rotate of z by k equals a, and the done timing matches the E0+k rule.
